// File: rtl/pc_pkg.sv
// ============================================================================
// Module : pc_pkg
// Brief  : Shared types and helpers for the fetch-stage program counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_t;

    // Number of low address bits covered by one sequential increment.
    function automatic int unsigned pc_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_redirect_buf.sv
// ============================================================================
// Module : pc_redirect_buf
// Brief  : Holds the most recent branch target seen while fetch is frozen.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set,
    input  logic [DATA_LEN-1:0] set_addr,
    input  logic                clr,
    output logic                pending,
    output logic [DATA_LEN-1:0] pend_addr
);

    logic                r_pending;
    logic [DATA_LEN-1:0] r_addr;

    // A new capture always overwrites: the latest branch wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_addr    <= '0;
        end else if (set) begin
            r_pending <= 1'b1;
            r_addr    <= set_addr;
        end else if (clr) begin
            r_pending <= 1'b0;
        end
    end

    assign pending   = r_pending;
    assign pend_addr = r_addr;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// Module : pc_fetch_ctrl
// Brief  : Fetch-stage PC with valid/ready handshake, branch redirect/kill,
//          freeze-time redirect buffer and saturating stall counter.
//          Define PC_ALIGN_CHECK_EN to align branch targets and flag faults.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int                DATA_LEN     = 32,
    parameter logic [DATA_LEN-1:0] RESET_VECTOR = '0,
    parameter int                INC_BYTES    = 4,
    parameter int                STALL_CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [DATA_LEN-1:0]    branch_addr,
    input  logic                   fetch_ready,
    output logic                   fetch_valid,
    output logic [DATA_LEN-1:0]    pc_out,
    output logic [DATA_LEN-1:0]    pc_seq,
    output logic                   fetch_kill,
    output logic                   redirect_pending,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   align_fault
);

    localparam logic [STALL_CNT_W-1:0] c_stall_max = '1;

    pc_state_t           r_state;
    pc_state_t           w_state_nxt;
    logic [DATA_LEN-1:0] r_pc;
    logic                r_kill;
    logic                r_align_fault;
    logic [STALL_CNT_W-1:0] r_stall;

    logic                w_load;
    logic                w_inc;
    logic [DATA_LEN-1:0] w_load_addr;
    logic [DATA_LEN-1:0] w_target;
    logic                w_misalign;
    logic                w_kill_nxt;
    logic                w_buf_set;
    logic                w_buf_clr;
    logic                w_pending;
    logic [DATA_LEN-1:0] w_pend_addr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_BOOT;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = freeze ? ST_HOLD : ST_RUN;
            ST_HOLD: w_state_nxt = freeze ? ST_HOLD : ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // Output / datapath control
    always_comb begin
        fetch_valid = 1'b0;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        w_load_addr = branch_addr;
        w_kill_nxt  = 1'b0;
        w_buf_set   = 1'b0;
        w_buf_clr   = 1'b0;
        case (r_state)
            ST_BOOT: w_load = branch_taken;
            ST_RUN: begin
                fetch_valid = !freeze;
                if (freeze) begin
                    w_buf_set = branch_taken;
                end else if (branch_taken) begin
                    w_load     = 1'b1;
                    w_kill_nxt = !fetch_ready;
                end else begin
                    w_inc = fetch_ready;
                end
            end
            ST_HOLD: begin
                if (freeze) begin
                    w_buf_set = branch_taken;
                end else begin
                    // A branch on the release cycle supersedes the buffered one.
                    w_buf_clr = 1'b1;
                    if (branch_taken) begin
                        w_load = 1'b1;
                    end else if (w_pending) begin
                        w_load      = 1'b1;
                        w_load_addr = w_pend_addr;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam int unsigned        c_align_bits = pc_log2(INC_BYTES);
    localparam logic [DATA_LEN-1:0] c_low_mask  = DATA_LEN'((64'd1 << c_align_bits) - 64'd1);
    assign w_target   = w_load_addr & ~c_low_mask;
    assign w_misalign = |(w_load_addr & c_low_mask);
`else
    assign w_target   = w_load_addr;
    assign w_misalign = 1'b0;
`endif

    pc_redirect_buf #(
        .DATA_LEN (DATA_LEN)
    ) u_redirect_buf (
        .clk       (clk),
        .rst       (rst),
        .set       (w_buf_set),
        .set_addr  (branch_addr),
        .clr       (w_buf_clr),
        .pending   (w_pending),
        .pend_addr (w_pend_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_VECTOR;
            r_kill        <= 1'b0;
            r_align_fault <= 1'b0;
            r_stall       <= '0;
        end else begin
            if (w_load)     r_pc <= w_target;
            else if (w_inc) r_pc <= pc_seq;
            r_kill        <= w_kill_nxt;
            r_align_fault <= w_load && w_misalign;
            if (fetch_valid && !fetch_ready && (r_stall != c_stall_max))
                r_stall <= r_stall + STALL_CNT_W'(1);
        end
    end

    assign pc_out           = r_pc;
    assign pc_seq           = r_pc + DATA_LEN'(INC_BYTES);
    assign fetch_kill       = r_kill;
    assign redirect_pending = w_pending;
    assign stall_cnt        = r_stall;
    assign align_fault      = r_align_fault;

endmodule

`default_nettype wire
